// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: carries fetch faults down the pipeline, enters and leaves the
// handler, and locks up on a nested fault. Optional mtval capture via the TRAP_MTVAL_EN macro.
`ifndef TRAP_CONTROLLER_DEFS
`define TRAP_CONTROLLER_DEFS
`define NO_E                    4'hF
`define E_FETCH_ADDR_MISALIGNED 4'h0
`define E_FETCH_ACCESS_FAULT    4'h1
`define E_ILLEGAL_INSTR         4'h2
`define E_BREAKPOINT            4'h3
`define E_LOAD_ADDR_MISALIGNED  4'h4
`define E_LOAD_ACCESS_FAULT     4'h5
`define E_STORE_ADDR_MISALIGNED 4'h6
`define E_STORE_ADDR_FAULT      4'h7
`define E_ECALL                 4'hB
`define E_SP_OUT_OF_RANGE       4'hE
`define PC_RESET_V              2'd0
`define PC_TXT                  2'd1
`define PC_TRAP_V               2'd2
`endif

module trap_controller #(
  parameter logic [31:0] P_TRAP_VECTOR = 32'h0000_0000,
  parameter logic [31:0] P_TEXT_BASE   = 32'h0008_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_exception_code_f,
  input  logic [3:0]  i_exception_code_e,
  input  logic [31:0] i_pc_f,
  input  logic [31:0] i_pc_e,
  input  logic [31:0] i_alu_out_e,
  input  logic        i_mret_e,
  input  logic        i_stall_d,
  input  logic        i_flush_d,
  input  logic        i_flush_e,
  output logic [1:0]  o_pc_state,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic [31:0] o_mepc,
  output logic [3:0]  o_mcause,
  output logic [31:0] o_mtval,
  output logic        o_lockup
);

  typedef enum logic [2:0] {
    S_RESET, S_RUN, S_ENTER, S_HANDLER, S_RETURN, S_LOCKUP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  dreg_q, dreg_d, ereg_q, ereg_d;
  logic [31:0] mepc_q, mepc_d;
  logic [3:0]  mcause_q, mcause_d;
  logic [3:0]  cause_e;
  logic        fault_e, take_trap;

  // A fetch fault that reached E is older than anything raised by E itself.
  assign cause_e   = (ereg_q != `NO_E) ? ereg_q : i_exception_code_e;
  assign fault_e   = (cause_e != `NO_E);
  assign take_trap = (state_q == S_RUN) && fault_e;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (fault_e)       state_d = S_ENTER;
        else if (i_mret_e) state_d = S_RETURN;
      end
      S_RESET, S_HANDLER: begin
        if (fault_e)       state_d = S_LOCKUP;
        else if (i_mret_e) state_d = S_RETURN;
      end
      S_ENTER:  state_d = S_HANDLER;
      S_RETURN: state_d = S_RUN;
      S_LOCKUP: state_d = S_LOCKUP;
      default:  state_d = S_RESET;
    endcase
  end

  always_comb begin
    o_redirect    = 1'b0;
    o_redirect_pc = '0;
    o_flush       = 1'b0;
    o_lockup      = 1'b0;
    o_pc_state    = `PC_TXT;
    case (state_q)
      S_RESET:   o_pc_state = `PC_RESET_V;
      S_ENTER: begin
        o_redirect    = 1'b1;
        o_flush       = 1'b1;
        o_redirect_pc = P_TRAP_VECTOR;
        o_pc_state    = `PC_TRAP_V;
      end
      S_HANDLER: o_pc_state = `PC_TRAP_V;
      S_RETURN: begin
        o_redirect    = 1'b1;
        o_flush       = 1'b1;
        o_redirect_pc = mepc_q;
      end
      S_LOCKUP: begin
        o_lockup   = 1'b1;
        o_flush    = 1'b1;
        o_pc_state = `PC_TRAP_V;
      end
      default: ;
    endcase
  end

  // Fetch-fault shadow pipeline, kept in step with the D and E pipeline registers.
  always_comb begin
    if (o_flush || i_flush_d) dreg_d = `NO_E;
    else if (i_stall_d)       dreg_d = dreg_q;
    else                      dreg_d = i_exception_code_f;
    ereg_d = (o_flush || i_flush_e) ? `NO_E : dreg_q;
  end

  always_comb begin
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (take_trap) begin
      mepc_d   = i_pc_e;
      mcause_d = cause_e;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dreg_q   <= `NO_E;
      ereg_q   <= `NO_E;
      mepc_q   <= P_TEXT_BASE;
      mcause_q <= `NO_E;
    end else begin
      dreg_q   <= dreg_d;
      ereg_q   <= ereg_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  assign o_mepc   = mepc_q;
  assign o_mcause = mcause_q;

`ifdef TRAP_MTVAL_EN
  logic [31:0] mtval_q, mtval_d;

  always_comb begin
    mtval_d = mtval_q;
    if (take_trap) begin
      case (cause_e)
        `E_FETCH_ADDR_MISALIGNED, `E_FETCH_ACCESS_FAULT:    mtval_d = i_pc_e;
        `E_LOAD_ADDR_MISALIGNED, `E_LOAD_ACCESS_FAULT,
        `E_STORE_ADDR_MISALIGNED, `E_STORE_ADDR_FAULT:      mtval_d = i_alu_out_e;
        default:                                            mtval_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mtval_q <= '0;
    else          mtval_q <= mtval_d;
  end

  assign o_mtval = mtval_q;

  logic unused_in;
  assign unused_in = ^i_pc_f;
`else
  assign o_mtval = '0;

  logic unused_in;
  assign unused_in = ^{i_pc_f, i_alu_out_e};
`endif

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 Parameter P_TRAP_VECTOR, default 32'h0000_0000, trap handler entry PC.
REQ-002 Parameter P_TEXT_BASE, default 32'h0008_0000, reset value of o_mepc.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_exception_code_f  in  4  fetch-stage exception code; `NO_E when none.
REQ-006 i_exception_code_e  in  4  execute-stage exception code; `NO_E when none.
REQ-007 i_pc_f / i_pc_e  in  32  PC of the fetch-stage / execute-stage instruction.
REQ-008 i_alu_out_e  in  32  execute-stage ALU result, the load/store address.
REQ-009 i_mret_e  in  1  mret instruction in execute stage.
REQ-010 i_stall_d, i_flush_d, i_flush_e  in  1  hazard-unit controls for the D and E pipeline registers.
REQ-011 o_pc_state  out  2  `PC_RESET_V / `PC_TXT / `PC_TRAP_V region indicator.
REQ-012 o_redirect  out  1  one-cycle PC redirect strobe; o_redirect_pc  out  32  redirect target.
REQ-013 o_flush  out  1  flush F, D and E pipeline registers.
REQ-014 o_mepc  out  32, o_mcause  out  4, o_mtval  out  32  trap CSR values.
REQ-015 o_lockup  out  1  double fault; core halts until reset.

Function
REQ-016 Fetch exception codes SHALL travel with their instruction: register D loads i_exception_code_f; register E loads register D.
REQ-017 Register D SHALL clear to `NO_E on o_flush or i_flush_d, else hold on i_stall_d, else load.
REQ-018 Register E SHALL clear to `NO_E on o_flush or i_flush_e, else load.
REQ-019 Effective E cause SHALL be register E when it is not `NO_E, else i_exception_code_e; the fetch fault has priority.
REQ-020 States: RESET, RUN, ENTER, HANDLER, RETURN, LOCKUP.
REQ-021 Transitions from RUN: effective cause != `NO_E goes to ENTER; otherwise i_mret_e goes to RETURN; otherwise stay.
REQ-022 Transitions from RESET and HANDLER: effective cause != `NO_E goes to LOCKUP; otherwise i_mret_e goes to RETURN.
REQ-023 ENTER SHALL go to HANDLER, and RETURN SHALL go to RUN; both ignore all inputs.
REQ-024 LOCKUP SHALL be absorbing until reset.
REQ-025 On the edge leaving RUN for ENTER, o_mepc<=i_pc_e and o_mcause<=effective cause (latency: redirect 1 cycle after the fault is seen in E).
REQ-026 ENTER outputs: o_redirect=1, o_flush=1, o_redirect_pc=P_TRAP_VECTOR.
REQ-027 RETURN outputs: o_redirect=1, o_flush=1, o_redirect_pc=o_mepc.
REQ-028 o_pc_state by state: RESET gives `PC_RESET_V; RUN and RETURN give `PC_TXT; ENTER, HANDLER and LOCKUP give `PC_TRAP_V.
REQ-029 LOCKUP outputs: o_lockup=1, o_flush=1 every cycle, o_redirect=0.
REQ-030 Outside ENTER and RETURN, o_redirect=0 and o_redirect_pc=0; o_flush=0 except in LOCKUP.
REQ-031 Simultaneous fault and i_mret_e: the fault wins.

Reset
REQ-032 Asynchronous reset SHALL set: state RESET, register D and register E to `NO_E, o_mepc=P_TEXT_BASE, o_mcause=`NO_E, o_mtval=0.
REQ-033 Reset mid-trap SHALL abandon ENTER, HANDLER or LOCKUP immediately.

Configuration
REQ-034 With TRAP_MTVAL_EN defined, o_mtval SHALL latch on the edge entering ENTER: i_pc_e for a fetch cause, i_alu_out_e for a load/store cause, 0 otherwise.
REQ-035 Without TRAP_MTVAL_EN, o_mtval SHALL be constant 0 and no mtval register is built.

Verification
REQ-036 Reset release, then i_mret_e=1 for one cycle -> RETURN cycle with o_redirect=1, o_redirect_pc=32'h0008_0000; then o_pc_state=`PC_TXT.
REQ-037 In RUN, i_exception_code_e=`E_LOAD_ADDR_MISALIGNED, i_pc_e=32'h0008_0010, i_alu_out_e=32'h0010_0003 -> next cycle: o_redirect=1, o_redirect_pc=0, o_mepc=32'h0008_0010, o_mcause=`E_LOAD_ADDR_MISALIGNED, o_mtval=32'h0010_0003 (macro on) or 0 (macro off).
REQ-038 `E_FETCH_ADDR_MISALIGNED injected at F with no stalls -> trap entered exactly 2 cycles later with that code; a repeat with i_stall_d high for 3 cycles delays entry by 3 cycles; i_flush_d coincident with the code loading D -> no trap.
REQ-039 Same cycle: register E holds `E_ILLEGAL_INSTR and i_exception_code_e=`E_STORE_ADDR_FAULT -> o_mcause=`E_ILLEGAL_INSTR.
REQ-040 In HANDLER, i_exception_code_e=`E_SP_OUT_OF_RANGE -> o_lockup=1 and o_flush=1 on every following cycle; i_mret_e is ignored; i_rst_n low -> RESET immediately.
